// File: rtl/aes192_round_key_gen.sv
// AES-192 key expansion engine: expands a 192-bit cipher key one word per clock
// into a 52-word schedule and serves 128-bit round keys by index with one cycle of latency.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Forward AES S-box, entry 0 in the leftmost byte.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[{in_byte, 3'b000} +: 8];

endmodule

module aes192_round_key_gen (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         KEY_LOAD,
  input  logic [0:191] CIPHER_KEY,
  input  logic [3:0]   RK_INDEX,
  output logic         BUSY,
  output logic         KEY_READY,
  output logic [0:127] ROUND_KEY
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  state_t       state_reg;
  logic [5:0]   word_idx_reg;
  logic [2:0]   phase_reg;
  logic [7:0]   rcon_reg;
  logic         busy_reg;
  logic         key_ready_reg;
  logic [0:127] round_key_reg;
  logic [31:0]  window_reg [6];
  logic [31:0]  w_mem [52];

  logic         load_accept;
  logic [31:0]  key_word [6];
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  temp_word;
  logic [31:0]  new_word;
  logic [0:127] rd_key;

  assign load_accept = KEY_LOAD && (state_reg != EXPAND);

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_key_word
      assign key_word[gi] = CIPHER_KEY[32*gi +: 32];
    end
  endgenerate

  // window_reg holds w[i-6..i-1], so the newest word is always slot 5.
  assign rot_word = {window_reg[5][23:0], window_reg[5][31:24]};

  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub_word
      aes_sbox u_sbox (
        .in_byte  (rot_word[8*gi +: 8]),
        .out_byte (sub_word[8*gi +: 8])
      );
    end
  endgenerate

  assign temp_word = (phase_reg == 3'd0) ? (sub_word ^ {rcon_reg, 24'h000000}) : window_reg[5];
  assign new_word  = window_reg[0] ^ temp_word;

  always_comb begin
    rd_key = '0;
    if (RK_INDEX <= 4'd12) begin
      rd_key = {w_mem[{RK_INDEX, 2'b00}], w_mem[{RK_INDEX, 2'b01}],
                w_mem[{RK_INDEX, 2'b10}], w_mem[{RK_INDEX, 2'b11}]};
    end
  end

  // Schedule storage has no reset: its contents are only exposed while KEY_READY is set.
  always_ff @(posedge CLK) begin
    if (load_accept) begin
      for (int k = 0; k < 6; k++) begin
        w_mem[k] <= key_word[k];
      end
    end else if (state_reg == EXPAND) begin
      w_mem[word_idx_reg] <= new_word;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      word_idx_reg  <= 6'd6;
      phase_reg     <= 3'd0;
      rcon_reg      <= 8'h01;
      busy_reg      <= 1'b0;
      key_ready_reg <= 1'b0;
      round_key_reg <= '0;
      for (int k = 0; k < 6; k++) begin
        window_reg[k] <= '0;
      end
    end else begin
      round_key_reg <= (key_ready_reg && (RK_INDEX <= 4'd12)) ? rd_key : '0;
      case (state_reg)
        IDLE, READY: begin
          if (KEY_LOAD) begin
            state_reg     <= EXPAND;
            busy_reg      <= 1'b1;
            key_ready_reg <= 1'b0;
            word_idx_reg  <= 6'd6;
            phase_reg     <= 3'd0;
            rcon_reg      <= 8'h01;
            for (int k = 0; k < 6; k++) begin
              window_reg[k] <= key_word[k];
            end
          end
        end
        EXPAND: begin
          for (int k = 0; k < 5; k++) begin
            window_reg[k] <= window_reg[k+1];
          end
          window_reg[5] <= new_word;
          word_idx_reg  <= word_idx_reg + 6'd1;
          phase_reg     <= (phase_reg == 3'd5) ? 3'd0 : phase_reg + 3'd1;
          // Only eight Rcon values are consumed, so the doubling never needs reduction.
          if (phase_reg == 3'd0) begin
            rcon_reg <= {rcon_reg[6:0], 1'b0};
          end
          if (word_idx_reg == 6'd51) begin
            state_reg     <= READY;
            busy_reg      <= 1'b0;
            key_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY      = busy_reg;
  assign KEY_READY = key_ready_reg;
  assign ROUND_KEY = round_key_reg;

endmodule

// File: tb/tb_aes192_round_key_gen.sv
// Scoreboard bench for aes192_round_key_gen: a driver issues per-cycle stimulus and queues the
// expected outputs from a transaction-level key-schedule model; a monitor pops and compares.

module tb_aes192_round_key_gen;

  logic         CLK;
  logic         RST_N;
  logic         KEY_LOAD;
  logic [0:191] CIPHER_KEY;
  logic [3:0]   RK_INDEX;
  logic         BUSY;
  logic         KEY_READY;
  logic [0:127] ROUND_KEY;

  aes192_round_key_gen dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .KEY_LOAD   (KEY_LOAD),
    .CIPHER_KEY (CIPHER_KEY),
    .RK_INDEX   (RK_INDEX),
    .BUSY       (BUSY),
    .KEY_READY  (KEY_READY),
    .ROUND_KEY  (ROUND_KEY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cycle_cnt = 0;
  always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    int           due;
    logic         busy;
    logic         ready;
    logic [0:127] rk;
    logic [3:0]   idx;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state
  logic [7:0]   sbox_tab [256];
  logic [0:127] m_sched [13];
  logic [0:127] m_pend [13];
  logic         m_busy = 1'b0;
  logic         m_ready = 1'b0;
  int           m_done = 0;

  logic [0:191] key_a2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  logic [0:191] key_c2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  logic [0:127] rk_a2_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  logic [0:127] rk_a2_12 = 128'he98ba06f448c773c8ecc720401002202;
  logic [0:127] rk_c2_0  = 128'h000102030405060708090a0b0c0d0e0f;
  logic [0:127] rk_c2_12 = 128'ha4970a331a78dc09c418c271e3a41d5d;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int k);
    logic [7:0] r = b;
    for (int j = 0; j < k; j++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its algebraic definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic compute_schedule(input logic [0:191] key);
    logic [31:0] wv [52];
    logic [31:0] t;
    for (int k = 0; k < 6; k++) wv[k] = key[32*k +: 32];
    for (int i = 6; i < 52; i++) begin
      t = wv[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {8'(1 << (i / 6 - 1)), 24'h000000};
      end
      wv[i] = wv[i-6] ^ t;
    end
    for (int r = 0; r < 13; r++) m_pend[r] = {wv[4*r], wv[4*r+1], wv[4*r+2], wv[4*r+3]};
  endtask

  function automatic logic [0:191] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [3:0] rand_idx();
    return 4'($urandom_range(0, 15));
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show after the edge that samples it.
  task automatic step(input logic ld, input logic [0:191] key, input logic [3:0] idx,
                      input logic [0:127] ref_rk, input logic use_ref);
    exp_t e;
    int   edge_n;
    logic accept;
    @(posedge CLK);
    #1;
    KEY_LOAD   = ld;
    CIPHER_KEY = key;
    RK_INDEX   = idx;
    edge_n = cycle_cnt + 1;
    e.due  = edge_n;
    e.idx  = idx;
    e.rk   = (m_ready && idx <= 4'd12) ? m_sched[idx] : '0;
    if (use_ref) e.rk = ref_rk;
    accept = ld && !m_busy;
    if (m_busy && edge_n == m_done) begin
      m_busy  = 1'b0;
      m_ready = 1'b1;
      m_sched = m_pend;
    end
    if (accept) begin
      m_busy  = 1'b1;
      m_ready = 1'b0;
      m_done  = edge_n + 46;
      compute_schedule(key);
    end
    e.busy  = m_busy;
    e.ready = m_ready;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if (BUSY !== 1'b0 || KEY_READY !== 1'b0 || ROUND_KEY !== '0) begin
      n_bad++;
      $display("FAIL %s: busy/ready/rk got %b/%b/%h expected 0/0/0", name, BUSY, KEY_READY, ROUND_KEY);
    end else begin
      $display("check %s: outputs zero", name);
    end
  endtask

  task automatic settle_and_reset(input string name);
    KEY_LOAD = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_zero(name);
    m_busy  = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Monitor: the output is presented every cycle; compare it against the entry due at this edge.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due < cycle_cnt) begin
      n_vec++;
      n_bad++;
      $display("FAIL stale_entry: due cycle %0d still queued at cycle %0d", sb[0].due, cycle_cnt);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cycle_cnt) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (BUSY !== e.busy || KEY_READY !== e.ready || ROUND_KEY !== e.rk) begin
        n_bad++;
        $display("FAIL read cyc=%0d idx=%0d: busy/ready/rk got %b/%b/%h expected %b/%b/%h",
                 cycle_cnt, e.idx, BUSY, KEY_READY, ROUND_KEY, e.busy, e.ready, e.rk);
      end else begin
        $display("vec cyc=%0d idx=%0d busy=%b ready=%b rk=%h ok", cycle_cnt, e.idx, BUSY, KEY_READY, ROUND_KEY);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not complete, %0d vectors checked", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    build_sbox();
    RST_N      = 1'b0;
    KEY_LOAD   = 1'b0;
    CIPHER_KEY = '0;
    RK_INDEX   = 4'd0;
    repeat (3) @(posedge CLK);
    #1;
    check_zero("power_on_reset");
    @(negedge CLK);
    RST_N = 1'b1;

    repeat (5) step(1'b0, rand_key(), rand_idx(), '0, 1'b0);

    // A.2 expansion with a C.2 load attempted at E10, which must be ignored
    step(1'b1, key_a2, 4'd0, '0, 1'b0);
    for (int k = 1; k <= 50; k++)
      step(k == 10, (k == 10) ? key_c2 : rand_key(), rand_idx(), '0, 1'b0);
    step(1'b0, rand_key(), 4'd1,  rk_a2_1,  1'b1);
    step(1'b0, rand_key(), 4'd12, rk_a2_12, 1'b1);
    step(1'b0, rand_key(), 4'd13, '0, 1'b0);
    step(1'b0, rand_key(), 4'd15, '0, 1'b0);

    // Reload C.2 from READY, then directed reads and a back-to-back sweep
    step(1'b1, key_c2, rand_idx(), '0, 1'b0);
    for (int k = 1; k <= 50; k++) step(1'b0, rand_key(), rand_idx(), '0, 1'b0);
    step(1'b0, rand_key(), 4'd0,  rk_c2_0,  1'b1);
    step(1'b0, rand_key(), 4'd12, rk_c2_12, 1'b1);
    for (int r = 0; r < 13; r++) step(1'b0, rand_key(), 4'(r), '0, 1'b0);

    // KEY_LOAD held high: restart on every READY entry
    for (int k = 0; k < 120; k++) step(1'b1, rand_key(), rand_idx(), '0, 1'b0);

    // Random traffic
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 39) == 0, rand_key(), rand_idx(), '0, 1'b0);

    // Asynchronous reset around E20 of an expansion
    for (int k = 0; k < 50; k++) step(1'b0, rand_key(), rand_idx(), '0, 1'b0);
    step(1'b1, key_a2, rand_idx(), '0, 1'b0);
    for (int k = 1; k <= 19; k++) step(1'b0, rand_key(), rand_idx(), '0, 1'b0);
    settle_and_reset("async_reset_mid_expand");
    for (int k = 0; k < 5; k++) step(1'b0, rand_key(), 4'd0, '0, 1'b0);

    // Recovery after reset
    step(1'b1, key_c2, rand_idx(), '0, 1'b0);
    for (int k = 1; k <= 50; k++) step(1'b0, rand_key(), rand_idx(), '0, 1'b0);
    for (int r = 0; r < 13; r++) step(1'b0, rand_key(), 4'(r), '0, 1'b0);
    step(1'b0, rand_key(), 4'd12, rk_c2_12, 1'b1);

    @(posedge CLK);
    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
